// File: rtl/hdlverifier_axis_pkg.sv
// Shared sizing constants and helpers for the FIFO-to-AXI4-Stream read adapter.
package hdlverifier_axis_pkg;

   // Output buffer holds a head word plus one skid word.
   localparam int BUF_DEPTH = 2;

   // Width of the occupancy count (0..BUF_DEPTH).
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   // Width of the free-running accepted-beat counter.
   localparam int BEAT_W = 32;

   // Width needed to count beats within one burst (0..burst_len-1); at least 1 bit.
   function automatic int clog2_burst(input int burst_len);
      return (burst_len <= 1) ? 1 : $clog2(burst_len);
   endfunction

endpackage

// File: rtl/hdlverifier_skid_buf2.sv
// Two-entry in-order output buffer: head drives the stream, skid absorbs the
// word that returns while head is still waiting on the consumer.
module hdlverifier_skid_buf2
   import hdlverifier_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  aclr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] skid;

   // Buffer update: push fills head when it is free (or leaving), else skid; pop promotes skid.
   always_ff @(posedge clk) begin
      if (aclr) begin
         occ  <= '0;
         head <= '0;
         skid <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == OCC_W'(0)) head <= din;
               else                  skid <= din;
               occ <= occ + OCC_W'(1);
            end
            2'b01: begin
               head <= skid;
               occ  <= occ - OCC_W'(1);
            end
            2'b11: begin
               // occ stays put; with two words skid advances and the new word refills it
               if (occ == OCC_W'(2)) begin
                  head <= skid;
                  skid <= din;
               end else begin
                  head <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hdlverifier_fifo_to_axis.sv
// Drains hdlverifier_sync_fifo through its rdreq/rdata/empty port and presents
// the words as an AXI4-Stream master with tlast framing fixed-length bursts.
// Reads are credit-limited so the 2-entry buffer can never overflow, and a read
// is never issued to an empty FIFO.
module hdlverifier_fifo_to_axis
   import hdlverifier_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  aclr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  fifo_rdreq,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [BEAT_W-1:0]     beat_count
);

   localparam int                BCNT_W    = clog2_burst(BURST_LEN);
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_LEN - 1);

   logic              infl;
   logic              pop;
   logic [OCC_W-1:0]  occ;
   logic [2:0]        credit;
   logic [BCNT_W-1:0] bcnt;

   assign pop    = m_axis_tvalid & m_axis_tready;
   // Words committed to the buffer after this cycle; a pop frees a slot immediately,
   // which lets rdreq rise in the same cycle tready does.
   assign credit = 3'(occ) + 3'(infl) - 3'(pop);

   assign fifo_rdreq    = en & ~fifo_empty & ~aclr & (credit < 3'd2);
   assign m_axis_tvalid = (occ != OCC_W'(0));
   assign m_axis_tlast  = m_axis_tvalid & (bcnt == BCNT_LAST);

   hdlverifier_skid_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk  (clk),
      .aclr (aclr),
      .push (infl),
      .din  (fifo_rdata),
      .pop  (pop),
      .occ  (occ),
      .head (m_axis_tdata)
   );

   // Read-in-flight flag: FIFO data lands one cycle after the strobe.
   always_ff @(posedge clk) begin
      if (aclr) infl <= 1'b0;
      else      infl <= fifo_rdreq;
   end

   // Burst position and total accepted beats, both advanced by each handshake.
   always_ff @(posedge clk) begin
      if (aclr) begin
         bcnt       <= '0;
         beat_count <= '0;
      end else if (pop) begin
         bcnt       <= (bcnt == BCNT_LAST) ? '0 : bcnt + BCNT_W'(1);
         beat_count <= beat_count + BEAT_W'(1);
      end
   end

endmodule

// File: tb/tb_hdlverifier_fifo_to_axis.sv
// Bench for hdlverifier_fifo_to_axis: a queue-based FIFO model feeds two DUTs
// (BURST_LEN 16 and 3) sharing one stream; a scoreboard of written words is the
// reference for order, data, tlast position and beat_count.
module tb_hdlverifier_fifo_to_axis;

   logic        clk = 1'b0;
   logic        aclr = 1'b1;
   logic        en = 1'b0;
   logic        tready = 1'b0;
   logic [31:0] fifo_rdata = '0;
   logic        fifo_empty = 1'b1;
   logic        rdreq, tvalid, tlast;
   logic [31:0] tdata, bc;
   logic        rdreq3, tvalid3, tlast3;
   logic [31:0] tdata3, bc3;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;

   logic [31:0] fq[$];
   logic [31:0] sb[$];
   int          nchk = 0;
   int          nerr = 0;
   int          nbeat = 0;
   int          nlast3 = 0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_d = '0;
   logic        prev_l = 1'b0;
   logic        m_rdreq, m_pop, m_tvalid, m_tlast;
   logic [31:0] m_bc, m_tdata;

   always #5 clk = ~clk;

   hdlverifier_fifo_to_axis #(.DATA_WIDTH(32), .BURST_LEN(16)) dut (
      .clk(clk), .aclr(aclr), .en(en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
      .fifo_rdreq(rdreq), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .m_axis_tlast(tlast), .beat_count(bc)
   );

   hdlverifier_fifo_to_axis #(.DATA_WIDTH(32), .BURST_LEN(3)) dut3 (
      .clk(clk), .aclr(aclr), .en(en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
      .fifo_rdreq(rdreq3), .m_axis_tdata(tdata3), .m_axis_tvalid(tvalid3),
      .m_axis_tready(tready), .m_axis_tlast(tlast3), .beat_count(bc3)
   );

   // FIFO model: one-cycle read latency, write lands at the clock edge, cleared by aclr.
   always @(posedge clk) begin
      if (aclr) begin
         fq.delete();
      end else begin
         if (rdreq && fq.size() > 0) fifo_rdata <= fq.pop_front();
         if (wr_en) fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle observation at the falling edge.
   task automatic monitor();
      logic [31:0] wd;
      m_rdreq  = rdreq;
      m_tvalid = tvalid;
      m_tlast  = tlast;
      m_tdata  = tdata;
      m_bc     = bc;
      m_pop    = tvalid & tready;
      if (rdreq)  chk("rdreq_while_empty", 32'(fifo_empty), 32'd0);
      if (rdreq3) chk("rdreq3_while_empty", 32'(fifo_empty), 32'd0);
      chk("occ_max", 32'(dut.u_buf.occ <= 2), 32'd1);
      if (dut.infl) chk("capture_when_full", 32'((dut.u_buf.occ == 2) && !m_pop), 32'd0);
      chk("beat_count", bc, nbeat);
      if (!tvalid) chk("tlast_idle", 32'(tlast), 32'd0);
      if (prev_stall) begin
         chk("stall_vld", 32'(tvalid), 32'd1);
         chk("stall_data", tdata, prev_d);
         chk("stall_last", 32'(tlast), 32'(prev_l));
      end
      if (m_pop) begin
         chk("word_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            wd = sb.pop_front();
            chk("tdata", tdata, wd);
            chk("tlast16", 32'(tlast), 32'((nbeat % 16) == 15));
            chk("tvalid3", 32'(tvalid3), 32'd1);
            chk("tdata3", tdata3, wd);
            chk("tlast3", 32'(tlast3), 32'((nbeat % 3) == 2));
         end
         if (tvalid3 && tlast3) nlast3++;
         nbeat++;
      end
      prev_stall = tvalid & ~tready;
      prev_d     = tdata;
      prev_l     = tlast;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      sb.push_back(d);
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget && sb.size() > 0; k++) tick();
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int first, last, npop, nrd;

      // reset values
      aclr = 1'b1;
      tick();
      tick();
      chk("rst_rdreq", 32'(m_rdreq), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_bc", m_bc, 32'd0);
      aclr = 1'b0;

      // preload 0x00..0x0F, then stream with tready high
      tready = 1'b1;
      for (int i = 0; i < 16; i++) put(32'(i));
      en = 1'b1;
      first = -1; last = -1; npop = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k < 16) chk("rdreq_stream", 32'(m_rdreq), 32'd1);
         if (m_pop) begin
            if (first < 0) first = k;
            last = k;
            npop++;
         end
      end
      chk("lat_first_beat", 32'(first), 32'd2);
      chk("burst_beats", 32'(npop), 32'd16);
      chk("back_to_back", 32'(last - first), 32'd15);
      chk("beat_count_16", m_bc, 32'd16);
      chk("idle_after_burst", 32'(m_tvalid), 32'd0);

      // tready toggling 1,0,0,1
      en = 1'b0;
      for (int i = 16; i < 32; i++) put(32'(i));
      en = 1'b1;
      for (int k = 0; k < 200 && sb.size() > 0; k++) begin
         tready = ((k % 4) == 0) || ((k % 4) == 3);
         tick();
      end
      chk("drain_toggle", 32'(sb.size()), 32'd0);
      tready = 1'b1;
      tick();
      tick();

      // single word
      put(32'hA5A5_0001);
      nrd = 0; npop = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         nrd  += int'(m_rdreq);
         npop += int'(m_pop);
      end
      chk("single_rdreq", 32'(nrd), 32'd1);
      chk("single_beat", 32'(npop), 32'd1);
      chk("single_idle", 32'(m_tvalid), 32'd0);

      // drop en the cycle after a read
      en = 1'b0;
      for (int i = 0; i < 8; i++) put(32'h2000 + 32'(i));
      en = 1'b1;
      tick();
      chk("en_c0_rdreq", 32'(m_rdreq), 32'd1);
      en = 1'b0;
      npop = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("en_low_no_rdreq", 32'(m_rdreq), 32'd0);
         npop += int'(m_pop);
      end
      chk("inflight_delivered", 32'(npop), 32'd1);
      en = 1'b1;
      drain("drain_en", 100);

      // reset with the buffer full and words still in the FIFO
      en = 1'b0;
      for (int i = 0; i < 4; i++) put(32'h3000 + 32'(i));
      tready = 1'b0;
      en = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("full_before_rst", 32'(dut.u_buf.occ), 32'd2);
      aclr = 1'b1;
      en = 1'b0;
      tick();
      aclr = 1'b0;
      sb.delete();
      nbeat = 0;
      nlast3 = 0;
      prev_stall = 1'b0;
      tick();
      chk("post_rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("post_rst_bc", m_bc, 32'd0);

      // seven words after reset: BURST_LEN=3 frames close on beats 3 and 6
      for (int i = 0; i < 7; i++) put($urandom);
      en = 1'b1;
      for (int k = 0; k < 300 && sb.size() > 0; k++) begin
         tready = ($urandom_range(0, 1) != 0);
         tick();
      end
      chk("drain_seven", 32'(sb.size()), 32'd0);
      chk("tlast3_count", 32'(nlast3), 32'd2);
      tready = 1'b1;
      tick();

      // random traffic: writes, backpressure and en toggling
      for (int k = 0; k < 1500; k++) begin
         tready = ($urandom_range(0, 3) != 0);
         en     = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 2) != 0 && fq.size() < 32) put($urandom);
         else tick();
      end
      en = 1'b1;
      tready = 1'b1;
      drain("drain_random", 200);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
